// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller and the EX-stage
// operand muxes: sequencing state encoding and forwarding-select encodings.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W     = 5;  // architectural register index width
  localparam int unsigned FCNT_W    = 2;  // bubble down-counter width (FLUSH_CYCLES up to 4)
  localparam int unsigned FLUSH_MAX = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  // Operand source select for the EX-stage muxes.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the controller.
//   master : pipeline side, drives register/stage status, receives controls
//   slave  : controller side, receives status, drives stall/flush/forward selects
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  // ID stage
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  // EX stage
  logic [REG_W-1:0] ex_rd;
  logic             ex_memRead;
  logic [REG_W-1:0] ex_rs1;
  logic [REG_W-1:0] ex_rs2;
  logic             ex_redirect;
  // Later stages
  logic [REG_W-1:0] exmem_rd;
  logic             exmem_regWrite;
  logic [REG_W-1:0] memwb_rd;
  logic             memwb_regWrite;
  logic             dmem_req;
  logic             dmem_ready;
  // Controls
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exmem_stall;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_memRead, ex_rs1, ex_rs2, ex_redirect,
    output exmem_rd, exmem_regWrite, memwb_rd, memwb_regWrite,
    output dmem_req, dmem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    input  exmem_stall, fwdA, fwdB
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_memRead, ex_rs1, ex_rs2, ex_redirect,
    input  exmem_rd, exmem_regWrite, memwb_rd, memwb_regWrite,
    input  dmem_req, dmem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    output exmem_stall, fwdA, fwdB
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
//   clk   : rising-edge clock
//   clr   : synchronous clear (highest priority)
//   inc   : add one unless already all-ones
//   count : current value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencing controller for a 5-stage pipeline.
// Detects data-memory wait states, EX-stage redirects and load-use hazards and
// drives stall/flush controls plus EX operand-forwarding selects. Controls are
// combinational from state and inputs; state and statistics are registered.
//   clk, rst  : clock, synchronous active-high reset
//   hz        : hazard-control bundle (slave side)
//   stall_cnt : saturating count of cycles with pc_stall asserted
//   flush_cnt : saturating count of redirect events
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam bit                USE_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
  logic flush_inc;
  logic mem_wait;
  logic load_use;
  fwd_sel_e fwd_a, fwd_b;

  // Newest producer wins; x0 is hard-wired zero and never forwarded.
  function automatic fwd_sel_e fwd_pick(
    input logic [REG_W-1:0] rs,
    input logic             exmem_we,
    input logic [REG_W-1:0] exmem_dst,
    input logic             memwb_we,
    input logic [REG_W-1:0] memwb_dst
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (exmem_we && (exmem_dst != '0) && (exmem_dst == rs)) begin
      sel = FWD_EXMEM;
    end else if (memwb_we && (memwb_dst != '0) && (memwb_dst == rs)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      fwd_a = fwd_pick(hz.ex_rs1, hz.exmem_regWrite, hz.exmem_rd,
                       hz.memwb_regWrite, hz.memwb_rd);
      fwd_b = fwd_pick(hz.ex_rs2, hz.exmem_regWrite, hz.exmem_rd,
                       hz.memwb_regWrite, hz.memwb_rd);
    end
  end

  always_comb begin
    load_use = hz.ex_memRead && (hz.ex_rd != '0) &&
               ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    // Once waiting, only dmem_ready releases the stall.
    if (state_q == ST_MEM_WAIT) begin
      mem_wait = !hz.dmem_ready;
    end else begin
      mem_wait = hz.dmem_req && !hz.dmem_ready;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    flush_inc   = 1'b0;

    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_RUN;
      fcnt_d     = '0;
    end else begin
      case (state_q)
        // The MEM_WAIT release cycle is evaluated like RUN, so a redirect held
        // by the frozen EX stage is acted on in that same cycle.
        ST_RUN, ST_MEM_WAIT: begin
          state_d = ST_RUN;
          if (mem_wait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            state_d     = ST_MEM_WAIT;
          end else if (hz.ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            if (USE_FLUSH) begin
              state_d = ST_FLUSH;
              fcnt_d  = FCNT_LOAD;
            end
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end

        // A memory wait during the bubble train freezes the whole pipe and
        // the bubble count; bubbles resume once memory completes.
        ST_FLUSH: begin
          if (hz.dmem_req && !hz.dmem_ready) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
          end else if (hz.ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            fcnt_d     = FCNT_LOAD;
          end else begin
            ifid_flush = 1'b1;
            fcnt_d     = fcnt_q - FCNT_W'(1);
            if (fcnt_q <= FCNT_W'(1)) begin
              state_d = ST_RUN;
              fcnt_d  = '0;
            end
          end
        end

        default: begin
          state_d = ST_RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (pc_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_stall  = idex_stall;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_stall = exmem_stall;
  assign hz.fwdA        = fwd_a;
  assign hz.fwdB        = fwd_b;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  logic [31:0] scnt_a, fcnt_a;
  logic [1:0]  scnt_b, fcnt_b;

  pipeline_hazard_ctrl_if bus_a ();
  pipeline_hazard_ctrl_if bus_b ();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .hz(bus_a.slave), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .hz(bus_b.slave), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, fwdA, fwdB}
  localparam logic [9:0] C_NONE = 10'b0000000000;
  localparam logic [9:0] C_RSTF = 10'b0010100000;
  localparam logic [9:0] C_REDR = 10'b0010100000;
  localparam logic [9:0] C_IFF  = 10'b0010000000;
  localparam logic [9:0] C_MEMW = 10'b1101010000;
  localparam logic [9:0] C_LU   = 10'b1100100000;

  typedef struct {
    int          dut;
    string       tag;
    logic [9:0]  ctrl;
    bit          cnt_en;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_of(input int d);
    if (d == 0)
      return {bus_a.pc_stall, bus_a.ifid_stall, bus_a.ifid_flush, bus_a.idex_stall,
              bus_a.idex_flush, bus_a.exmem_stall, bus_a.fwdA, bus_a.fwdB};
    return {bus_b.pc_stall, bus_b.ifid_stall, bus_b.ifid_flush, bus_b.idex_stall,
            bus_b.idex_flush, bus_b.exmem_stall, bus_b.fwdA, bus_b.fwdB};
  endfunction

  // Output side of the scoreboard: compare everything queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, ".ctrl"}, 32'(ctrl_of(e.dut)), 32'(e.ctrl));
      if (e.cnt_en) begin
        check_eq({e.tag, ".stall_cnt"}, (e.dut == 0) ? scnt_a : 32'(scnt_b), e.scnt);
        check_eq({e.tag, ".flush_cnt"}, (e.dut == 0) ? fcnt_a : 32'(fcnt_b), e.fcnt);
      end
    end
  end

  task automatic clr_in();
    bus_a.id_rs1 = '0; bus_a.id_rs2 = '0; bus_a.id_use_rs1 = 0; bus_a.id_use_rs2 = 0;
    bus_a.ex_rd = '0; bus_a.ex_memRead = 0; bus_a.ex_rs1 = '0; bus_a.ex_rs2 = '0;
    bus_a.ex_redirect = 0; bus_a.exmem_rd = '0; bus_a.exmem_regWrite = 0;
    bus_a.memwb_rd = '0; bus_a.memwb_regWrite = 0; bus_a.dmem_req = 0; bus_a.dmem_ready = 0;
    bus_b.id_rs1 = '0; bus_b.id_rs2 = '0; bus_b.id_use_rs1 = 0; bus_b.id_use_rs2 = 0;
    bus_b.ex_rd = '0; bus_b.ex_memRead = 0; bus_b.ex_rs1 = '0; bus_b.ex_rs2 = '0;
    bus_b.ex_redirect = 0; bus_b.exmem_rd = '0; bus_b.exmem_regWrite = 0;
    bus_b.memwb_rd = '0; bus_b.memwb_regWrite = 0; bus_b.dmem_req = 0; bus_b.dmem_ready = 0;
  endtask

  // Input side: inputs are already driven; queue the expectation, let the
  // monitor compare at the falling edge, then move past the next rising edge.
  task automatic step(input int d, input string tag, input logic [9:0] c,
                      input bit cen, input int unsigned s, input int unsigned f);
    exp_t e;
    e.dut = d; e.tag = tag; e.ctrl = c; e.cnt_en = cen; e.scnt = s; e.fcnt = f;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clr_in();
    // Reset, enter MEM_WAIT, then reset mid-wait.
    step(0, "rst0", C_RSTF, 1, 0, 0);
    rst = 0; bus_a.dmem_req = 1;
    step(0, "mw1", C_MEMW, 1, 0, 0);
    step(0, "mw2", C_MEMW, 1, 1, 0);
    rst = 1;
    step(0, "rst_mw1", C_RSTF, 1, 2, 0);
    step(0, "rst_mw2", C_RSTF, 1, 0, 0);
    rst = 0; clr_in();
    step(0, "post_rst_run", C_NONE, 1, 0, 0);
    // Load-use via rs1 and via rs2.
    bus_a.ex_memRead = 1; bus_a.ex_rd = 5; bus_a.id_rs1 = 5; bus_a.id_use_rs1 = 1;
    bus_a.id_rs2 = 7; bus_a.id_use_rs2 = 1;
    step(0, "lu_rs1", C_LU, 1, 0, 0);
    clr_in();
    step(0, "lu_after", C_NONE, 1, 1, 0);
    bus_a.ex_memRead = 1; bus_a.ex_rd = 12; bus_a.id_rs2 = 12; bus_a.id_use_rs2 = 1;
    bus_a.id_rs1 = 3; bus_a.id_use_rs1 = 1;
    step(0, "lu_rs2", C_LU, 0, 0, 0);
    clr_in();
    step(0, "lu2_after", C_NONE, 1, 2, 0);
    // No stall for x0 destination or unused operand.
    bus_a.ex_memRead = 1; bus_a.ex_rd = 0; bus_a.id_rs1 = 0; bus_a.id_use_rs1 = 1;
    step(0, "lu_x0", C_NONE, 0, 0, 0);
    bus_a.ex_rd = 8; bus_a.id_rs2 = 8; bus_a.id_use_rs2 = 0; bus_a.id_rs1 = 1;
    step(0, "lu_unused", C_NONE, 1, 2, 0);
    clr_in();
    // Forwarding.
    bus_a.exmem_rd = 9; bus_a.memwb_rd = 9; bus_a.exmem_regWrite = 1; bus_a.memwb_regWrite = 1;
    bus_a.ex_rs1 = 9; bus_a.ex_rs2 = 4;
    step(0, "fwd_exmem", {6'b0, 2'b10, 2'b00}, 0, 0, 0);
    bus_a.exmem_regWrite = 0;
    step(0, "fwd_memwb", {6'b0, 2'b01, 2'b00}, 0, 0, 0);
    bus_a.exmem_regWrite = 1; bus_a.exmem_rd = 0; bus_a.memwb_rd = 0; bus_a.ex_rs1 = 0;
    step(0, "fwd_x0", {6'b0, 2'b00, 2'b00}, 0, 0, 0);
    bus_a.exmem_rd = 4; bus_a.memwb_rd = 9; bus_a.ex_rs1 = 9; bus_a.ex_rs2 = 4;
    step(0, "fwd_mixed", {6'b0, 2'b01, 2'b10}, 0, 0, 0);
    bus_a.memwb_regWrite = 0; bus_a.exmem_rd = 3; bus_a.ex_rs1 = 3; bus_a.ex_rs2 = 3;
    step(0, "fwd_both", {6'b0, 2'b10, 2'b10}, 0, 0, 0);
    clr_in();
    // Redirect held through a memory wait.
    rst = 1;
    step(0, "rst_t5", C_RSTF, 0, 0, 0);
    rst = 0; bus_a.dmem_req = 1; bus_a.ex_redirect = 1;
    step(0, "mwr1", C_MEMW, 1, 0, 0);
    step(0, "mwr2", C_MEMW, 0, 0, 0);
    step(0, "mwr3", C_MEMW, 0, 0, 0);
    bus_a.dmem_ready = 1;
    step(0, "mwr_release", C_REDR, 1, 3, 0);
    clr_in();
    step(0, "mwr_after", C_NONE, 1, 3, 1);
    // Redirect overrides load-use.
    bus_a.ex_redirect = 1; bus_a.ex_memRead = 1; bus_a.ex_rd = 5;
    bus_a.id_rs1 = 5; bus_a.id_use_rs1 = 1;
    step(0, "redir_over_lu", C_REDR, 0, 0, 0);
    clr_in();
    step(0, "redir_after", C_NONE, 1, 3, 2);

    // Multi-cycle flush with 2-bit counters.
    rst = 1;
    step(1, "b_rst", C_RSTF, 0, 0, 0);
    rst = 0; bus_b.ex_redirect = 1;
    step(1, "b_redir", C_REDR, 1, 0, 0);
    bus_b.ex_redirect = 0;
    step(1, "b_fl1", C_IFF, 1, 0, 1);
    step(1, "b_fl2", C_IFF, 0, 0, 0);
    step(1, "b_done", C_NONE, 1, 0, 1);
    rst = 1;
    step(1, "b_rst2", C_RSTF, 0, 0, 0);
    rst = 0; bus_b.ex_redirect = 1;
    step(1, "b_r1", C_REDR, 1, 0, 0);
    step(1, "b_r2", C_REDR, 0, 0, 0);
    bus_b.ex_redirect = 0;
    step(1, "b_x1", C_IFF, 1, 0, 2);
    step(1, "b_x2", C_IFF, 0, 0, 0);
    step(1, "b_xdone", C_NONE, 1, 0, 2);
    bus_b.ex_redirect = 1;
    step(1, "b_r3", C_REDR, 0, 0, 0);
    bus_b.ex_redirect = 0;
    step(1, "b_y1", C_IFF, 1, 0, 3);
    step(1, "b_y2", C_IFF, 0, 0, 0);
    bus_b.ex_redirect = 1;
    step(1, "b_r4", C_REDR, 1, 0, 3);
    bus_b.ex_redirect = 0;
    step(1, "b_fsat", C_IFF, 1, 0, 3);
    step(1, "b_z2", C_IFF, 0, 0, 0);
    step(1, "b_zdone", C_NONE, 0, 0, 0);
    bus_b.dmem_req = 1;
    for (int i = 0; i < 5; i++) begin
      step(1, $sformatf("b_mw%0d", i), C_MEMW, (i == 0), 0, 3);
    end
    bus_b.dmem_ready = 1;
    step(1, "b_ssat", C_NONE, 1, 3, 3);
    clr_in();
    step(1, "b_ssat_hold", C_NONE, 1, 3, 3);

    @(negedge clk);
    #1;
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
